// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and defaults for the scroller sequencer.
//   state_t   sequencer states (FETCH, WAIT, LOAD, HOLD)
//   *_DEF     default parameter values
//   cnt_w()   register width needed to hold the values 0..n-1
package scroll_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      LOAD  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int TICK_DIV_DEF        = 25_000_000;
   localparam int READ_LAT_DEF        = 2;
   localparam int SHIFTS_PER_WORD_DEF = 8;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: shift-step prescaler.
//   clk_sys  clock
//   rst_b    async active-low reset
//   clr      return the count to 0 (has priority over en)
//   en       count this cycle; when disabled the count is held
//   tick     high for the enabled cycle in which the count is TICK_DIV-1
// tick is decoded from the count register so the sequencer can register
// shift_en on the same edge where the prescaler wraps to 0.
module scroll_tick_gen
   import scroll_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            W    = cnt_w(TICK_DIV);
   localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: sequencer for the eight-digit scroller datapath.
// Fetches message words from the BRAM read port, loads each one into the
// circular shift register, rotates it with timed shift pulses, then moves
// on to the next word (wrapping after NUM_WORDS).
//   CLK100MHZ   clock
//   CPU_RESETN  async active-low reset
//   run         1 = scrolling advances, 0 = prescaler frozen
//   restart     pulse: back to word 0
//   step        (SCROLL_STEP_EN only) manual shift while run=0 in HOLD
//   enb/addrb   BRAM port-B read enable / address
//   load_en     shift register captures doutb
//   shift_en    shift register rotates one digit
//   wrap        final shift of the last word
// Optional feature macro: SCROLL_STEP_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | issue enb for one cycle with addrb = word index
// WAIT  | wait out the remaining BRAM read latency
// LOAD  | pulse load_en while doutb is valid, clear shift/prescaler
// HOLD  | issue shift_en on each tick; after the last shift go to FETCH
module scroll_ctrl
   import scroll_pkg::*;
#(
   parameter int TICK_DIV        = TICK_DIV_DEF,
   parameter int ADDR_W          = 4,
   parameter int NUM_WORDS       = 16,
   parameter int READ_LAT        = READ_LAT_DEF,
   parameter int SHIFTS_PER_WORD = SHIFTS_PER_WORD_DEF
) (
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   input  logic              run,
   input  logic              restart,
`ifdef SCROLL_STEP_EN
   input  logic              step,
`endif
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   output logic              load_en,
   output logic              shift_en,
   output logic              wrap
);

   localparam int                SW         = cnt_w(SHIFTS_PER_WORD);
   localparam logic [SW-1:0]     LAST_SHIFT = SW'(SHIFTS_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(NUM_WORDS - 1);
   localparam int                WW         = cnt_w(READ_LAT);
   // WAIT is a down-counter; with a latency of 1 the LOAD follows FETCH
   // directly and WAIT is never entered.
   localparam logic [WW-1:0]     WAIT_LOAD  = WW'((READ_LAT >= 2) ? READ_LAT - 2 : 0);

   state_t             state;
   logic [ADDR_W-1:0]  word_idx;
   logic [SW-1:0]      shift_cnt;
   logic [WW-1:0]      wait_cnt;
   logic               tick;
   logic               tick_clr;
   logic               tick_en;
   logic               step_hit;

   // restart clears the prescaler and suppresses a coincident tick
   assign tick_clr = restart || (state == LOAD);
   assign tick_en  = (state == HOLD) && run && !restart;

`ifdef SCROLL_STEP_EN
   assign step_hit = (state == HOLD) && step && !run;
`else
   assign step_hit = 1'b0;
`endif

   scroll_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_sys (CLK100MHZ),
      .rst_b   (CPU_RESETN),
      .clr     (tick_clr),
      .en      (tick_en),
      .tick    (tick)
   );

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state     <= FETCH;
         word_idx  <= '0;
         shift_cnt <= '0;
         wait_cnt  <= '0;
         enb       <= 1'b0;
         addrb     <= '0;
         load_en   <= 1'b0;
         shift_en  <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         enb      <= 1'b0;
         load_en  <= 1'b0;
         shift_en <= 1'b0;
         wrap     <= 1'b0;
         if (restart) begin
            state     <= FETCH;
            word_idx  <= '0;
            shift_cnt <= '0;
            addrb     <= '0;
         end else begin
            case (state)
               FETCH: begin
                  enb      <= 1'b1;
                  addrb    <= word_idx;
                  wait_cnt <= WAIT_LOAD;
                  state    <= (READ_LAT >= 2) ? WAIT : LOAD;
               end
               WAIT: begin
                  if (wait_cnt == '0) begin
                     state <= LOAD;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
               LOAD: begin
                  load_en   <= 1'b1;
                  shift_cnt <= '0;
                  state     <= HOLD;
               end
               HOLD: begin
                  if (tick || step_hit) begin
                     shift_en <= 1'b1;
                     if (shift_cnt == LAST_SHIFT) begin
                        shift_cnt <= '0;
                        state     <= FETCH;
                        if (word_idx == LAST_WORD) begin
                           wrap     <= 1'b1;
                           word_idx <= '0;
                        end else begin
                           word_idx <= word_idx + 1'b1;
                        end
                     end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                     end
                  end
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: self-checking bench for scroll_ctrl (TICK_DIV=4,
// READ_LAT=2, NUM_WORDS=6, 8 shifts per word).
module tb_scroll_ctrl;

   localparam int TD  = 4;
   localparam int AW  = 4;
   localparam int NW  = 6;
   localparam int RL  = 2;
   localparam int SPW = 8;
`ifdef SCROLL_STEP_EN
   localparam bit HAS_STEP = 1'b1;
`else
   localparam bit HAS_STEP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          restart = 1'b0;
   logic          step = 1'b0;
   logic          enb, load_en, shift_en, wrap;
   logic [AW-1:0] addrb;

   int checks = 0;
   int failures = 0;

   scroll_ctrl #(
      .TICK_DIV        (TD),
      .ADDR_W          (AW),
      .NUM_WORDS       (NW),
      .READ_LAT        (RL),
      .SHIFTS_PER_WORD (SPW)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .run        (run),
      .restart    (restart),
`ifdef SCROLL_STEP_EN
      .step       (step),
`endif
      .enb        (enb),
      .addrb      (addrb),
      .load_en    (load_en),
      .shift_en   (shift_en),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      run = 1'b0;
      restart = 1'b0;
      step = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic wait_fetch(input int a, input string nm);
      int k;
      for (k = 0; k < 2000; k++) begin
         clk_step();
         if (enb && addrb == AW'(a)) break;
      end
      chk(nm, int'(k < 2000), 1);
   endtask

   task automatic wait_load(input string nm);
      int k;
      for (k = 0; k < 2000; k++) begin
         clk_step();
         if (load_en) break;
      end
      chk(nm, int'(k < 2000), 1);
   endtask

   // Reference model: time since the word's fetch, shifts done, prescaler.
   int m_t, m_word, m_s, m_p;
   int e_enb, e_addr, e_ld, e_sh, e_wr;

   task automatic model_reset();
      m_t = 0; m_word = 0; m_s = 0; m_p = 0;
      e_enb = 0; e_addr = 0; e_ld = 0; e_sh = 0; e_wr = 0;
   endtask

   task automatic model_step(input bit r, input bit rs, input bit st);
      bit adv;
      adv = 1'b0;
      e_enb = 0; e_ld = 0; e_sh = 0; e_wr = 0;
      if (rs) begin
         m_t = 0; m_word = 0; m_s = 0; m_p = 0; e_addr = 0;
      end else if (m_t == 0) begin
         e_enb = 1; e_addr = m_word; m_t = 1;
      end else if (m_t < RL) begin
         m_t++;
      end else if (m_t == RL) begin
         e_ld = 1; m_s = 0; m_p = 0; m_t++;
      end else begin
         if (r) begin
            if (m_p == TD - 1) begin
               adv = 1'b1;
               m_p = 0;
            end else begin
               m_p++;
            end
         end else if (st && HAS_STEP) begin
            adv = 1'b1;
         end
         if (adv) begin
            e_sh = 1;
            m_s++;
            if (m_s == SPW) begin
               m_t = 0;
               if (m_word == NW - 1) begin
                  e_wr = 1;
                  m_word = 0;
               end else begin
                  m_word++;
               end
            end
         end
      end
   endtask

   typedef struct {
      int cyc;
      int e_enb;
      int e_addr;
      int e_ld;
      int e_sh;
      int e_wr;
   } vec_t;

   vec_t tv[$];

   initial begin
      int cyc;
      int n, lowshifts, lat, total, fetches, wraps;
      int seq[$];

      // ---------------- first word timeline (table-driven) -------------
      tv.push_back('{0,  0, 0, 0, 0, 0});
      tv.push_back('{1,  1, 0, 0, 0, 0});
      tv.push_back('{2,  0, 0, 0, 0, 0});
      tv.push_back('{3,  0, 0, 1, 0, 0});
      tv.push_back('{4,  0, 0, 0, 0, 0});
      tv.push_back('{6,  0, 0, 0, 0, 0});
      tv.push_back('{7,  0, 0, 0, 1, 0});
      tv.push_back('{8,  0, 0, 0, 0, 0});
      tv.push_back('{11, 0, 0, 0, 1, 0});
      tv.push_back('{34, 0, 0, 0, 0, 0});
      tv.push_back('{35, 0, 0, 0, 1, 0});
      tv.push_back('{36, 1, 1, 0, 0, 0});

      do_reset();
      run = 1'b1;
      cyc = 0;
      foreach (tv[i]) begin
         while (cyc < tv[i].cyc) begin
            clk_step();
            cyc++;
         end
         chk($sformatf("c%0d_enb", cyc),   int'(enb),      tv[i].e_enb);
         chk($sformatf("c%0d_addrb", cyc), int'(addrb),    tv[i].e_addr);
         chk($sformatf("c%0d_load", cyc),  int'(load_en),  tv[i].e_ld);
         chk($sformatf("c%0d_shift", cyc), int'(shift_en), tv[i].e_sh);
         chk($sformatf("c%0d_wrap", cyc),  int'(wrap),     tv[i].e_wr);
      end

      // ---------------- free run: address sequence and wrap -------------
      do_reset();
      run = 1'b1;
      fetches = 0;
      wraps = 0;
      for (int c = 0; c < 400 && fetches < NW + 1; c++) begin
         clk_step();
         if (enb) begin
            seq.push_back(int'(addrb));
            fetches++;
         end
         if (wrap) begin
            wraps++;
            chk("wrap_with_shift", int'(shift_en), 1);
            chk("wrap_word", int'(addrb), NW - 1);
         end
      end
      chk("fetch_count", fetches, NW + 1);
      foreach (seq[i]) chk($sformatf("fetch%0d_addr", i), seq[i], i % NW);
      chk("wrap_count", wraps, 1);

      // ---------------- run low after 3 shifts ---------------------------
      do_reset();
      run = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && n < 3; c++) begin
         clk_step();
         if (shift_en) n++;
      end
      chk("three_shifts", n, 3);
      clk_step();                       // prescaler now holds 1
      run = 1'b0;
      lowshifts = 0;
      for (int c = 0; c < 20; c++) begin
         clk_step();
         if (shift_en) lowshifts++;
      end
      chk("no_shift_run_low", lowshifts, 0);
      run = 1'b1;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         clk_step();
         if (shift_en) begin
            lat = c;
            break;
         end
      end
      chk("resume_latency", lat, (TD - 1) - 1 + 1);
      total = 4;
      for (int c = 0; c < 200; c++) begin
         clk_step();
         if (enb) break;
         if (shift_en) total++;
      end
      chk("shifts_per_word", total, SPW);
      chk("next_fetch_addr", int'(addrb), 1);

      // ---------------- restart in WAIT of word 5 ------------------------
      do_reset();
      run = 1'b1;
      wait_fetch(5, "reach_word5");
      restart = 1'b1;
      clk_step();
      restart = 1'b0;
      chk("restart_no_load", int'(load_en), 0);
      chk("restart_no_enb", int'(enb), 0);
      clk_step();
      chk("restart_fetch_enb", int'(enb), 1);
      chk("restart_fetch_addr", int'(addrb), 0);

      // ---------------- restart coincident with a tick -------------------
      wait_load("reach_load_w0");
      repeat (TD - 1) clk_step();
      restart = 1'b1;
      clk_step();
      restart = 1'b0;
      chk("restart_tick_no_shift", int'(shift_en), 0);
      chk("restart_tick_no_load", int'(load_en), 0);
      clk_step();
      chk("restart_tick_fetch_enb", int'(enb), 1);
      chk("restart_tick_fetch_addr", int'(addrb), 0);

      // ---------------- async reset mid-operation ------------------------
      do_reset();
      run = 1'b1;
      wait_fetch(1, "reach_word1");
      wait_load("reach_load_w1");
      chk("pre_reset_addr", int'(addrb), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_enb", int'(enb), 0);
      chk("async_addrb", int'(addrb), 0);
      chk("async_load", int'(load_en), 0);
      chk("async_shift", int'(shift_en), 0);
      chk("async_wrap", int'(wrap), 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      clk_step();
      chk("post_reset_enb", int'(enb), 1);
      chk("post_reset_addr", int'(addrb), 0);

`ifdef SCROLL_STEP_EN
      // ---------------- manual step ------------------------------------
      do_reset();
      run = 1'b0;
      wait_load("step_reach_load");
      for (int i = 0; i < SPW; i++) begin
         step = 1'b1;
         clk_step();
         step = 1'b0;
         chk($sformatf("step%0d_shift", i), int'(shift_en), 1);
         clk_step();
         if (i < SPW - 1) begin
            chk($sformatf("step%0d_gap", i), int'(shift_en), 0);
         end else begin
            chk("step_fetch_enb", int'(enb), 1);
            chk("step_fetch_addr", int'(addrb), 1);
         end
      end
      wait_load("step_reach_load_w1");
      run = 1'b1;
      step = 1'b1;
      clk_step();
      step = 1'b0;
      chk("step_ignored_run1", int'(shift_en), 0);
      run = 1'b0;
`endif

      // ---------------- randomized run against the model -----------------
      do_reset();
      model_reset();
      run = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         restart = ($urandom_range(0, 399) == 0);
         step = ($urandom_range(0, 3) == 0);
         clk_step();
         model_step(run, restart, step);
         chk("rnd_enb",   int'(enb),      e_enb);
         chk("rnd_addrb", int'(addrb),    e_addr);
         chk("rnd_load",  int'(load_en),  e_ld);
         chk("rnd_shift", int'(shift_en), e_sh);
         chk("rnd_wrap",  int'(wrap),     e_wr);
      end
      restart = 1'b0;
      step = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
